// File: rtl/multicycle_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | multicycle_ctrl_if : decode/status inputs and control strobes of the       |
// |                      multicycle controller, grouped as one bundle.         |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface multicycle_ctrl_if #(
  parameter int CODE_W = 54
);
  logic [CODE_W-1:0] code;
  logic              zero;
  logic              rs_sign;
  logic              mem_ready;
  logic              ir_we;
  logic              pc_we;
  logic [2:0]        pc_sel;
  logic              rf_w;
  logic              dm_r;
  logic              dm_w;
  logic              hi_ena;
  logic              lo_ena;
  logic              md_start;
  logic              busy;
  logic              exception;
  logic [4:0]        cause;
  logic [2:0]        state;

  modport master (
    input  code, zero, rs_sign, mem_ready,
    output ir_we, pc_we, pc_sel, rf_w, dm_r, dm_w, hi_ena, lo_ena,
           md_start, busy, exception, cause, state
  );

  modport slave (
    output code, zero, rs_sign, mem_ready,
    input  ir_we, pc_we, pc_sel, rf_w, dm_r, dm_w, hi_ena, lo_ena,
           md_start, busy, exception, cause, state
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// +----------------------------------------------------------------------------+
// | multicycle_ctrl : IF/ID/EX/MEM/WB/MD/EXC control FSM for a 54-instruction  |
// |                   multicycle MIPS core with multiply/divide and CP0 traps. |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module multicycle_ctrl #(
  parameter int CODE_W     = 54,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 6
) (
  input  wire logic         clk,
  input  wire logic         rst,
  multicycle_ctrl_if.master bus
);

  localparam logic [2:0] c_ST_IF  = 3'd0;
  localparam logic [2:0] c_ST_ID  = 3'd1;
  localparam logic [2:0] c_ST_EX  = 3'd2;
  localparam logic [2:0] c_ST_MEM = 3'd3;
  localparam logic [2:0] c_ST_WB  = 3'd4;
  localparam logic [2:0] c_ST_MD  = 3'd5;
  localparam logic [2:0] c_ST_EXC = 3'd6;

  localparam logic [2:0] c_PC_SEQ = 3'd0;
  localparam logic [2:0] c_PC_BR  = 3'd1;
  localparam logic [2:0] c_PC_JT  = 3'd2;
  localparam logic [2:0] c_PC_RS  = 3'd3;
  localparam logic [2:0] c_PC_EPC = 3'd4;
  localparam logic [2:0] c_PC_VEC = 3'd5;

  localparam logic [4:0] c_EXC_SYS = 5'b01000;
  localparam logic [4:0] c_EXC_BP  = 5'b01001;
  localparam logic [4:0] c_EXC_RI  = 5'b01010;
  localparam logic [4:0] c_EXC_TR  = 5'b01101;

  localparam logic [CNT_W-1:0]  c_MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0]  c_DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);
  localparam logic [CODE_W-1:0] c_CODE_ONE = CODE_W'(1);

  // Bit positions in the one-hot decode vector.
  localparam int c_I_JR      = 16;
  localparam int c_I_LW      = 22;
  localparam int c_I_SW      = 23;
  localparam int c_I_BEQ     = 24;
  localparam int c_I_BNE     = 25;
  localparam int c_I_J       = 29;
  localparam int c_I_JAL     = 30;
  localparam int c_I_DIVU    = 32;
  localparam int c_I_ERET    = 33;
  localparam int c_I_JALR    = 34;
  localparam int c_I_LB      = 35;
  localparam int c_I_LBU     = 36;
  localparam int c_I_LHU     = 37;
  localparam int c_I_SB      = 38;
  localparam int c_I_SH      = 39;
  localparam int c_I_LH      = 40;
  localparam int c_I_MTHI    = 45;
  localparam int c_I_MTLO    = 46;
  localparam int c_I_MULT    = 47;
  localparam int c_I_MULTU   = 48;
  localparam int c_I_SYSCALL = 49;
  localparam int c_I_TEQ     = 50;
  localparam int c_I_BGEZ    = 51;
  localparam int c_I_BREAK   = 52;
  localparam int c_I_DIV     = 53;

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [4:0]        r_cause;

  logic [2:0]        w_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [4:0]        w_cause_next;

  logic [CODE_W-1:0] w_sel;
  logic              w_any;
  logic              w_load;
  logic              w_store;
  logic              w_mul;
  logic              w_div;
  logic              w_branch;
  logic              w_taken;
  logic              w_cnt_zero;

  logic              w_ir_we;
  logic              w_pc_we;
  logic [2:0]        w_pc_sel;
  logic              w_rf_w;
  logic              w_dm_r;
  logic              w_dm_w;
  logic              w_hi_ena;
  logic              w_lo_ena;
  logic              w_md_start;
  logic              w_exception;

  // Isolate the lowest set bit so multi-hot codes decode as that instruction.
  assign w_sel   = bus.code & (~bus.code + c_CODE_ONE);
  assign w_any   = |w_sel;

  assign w_load  = w_sel[c_I_LW] | w_sel[c_I_LH] | w_sel[c_I_LHU] |
                   w_sel[c_I_LB] | w_sel[c_I_LBU];
  assign w_store = w_sel[c_I_SW] | w_sel[c_I_SH] | w_sel[c_I_SB];
  assign w_mul   = w_sel[c_I_MULT] | w_sel[c_I_MULTU];
  assign w_div   = w_sel[c_I_DIV] | w_sel[c_I_DIVU];
  assign w_branch = w_sel[c_I_BEQ] | w_sel[c_I_BNE] | w_sel[c_I_BGEZ];
  assign w_taken  = (w_sel[c_I_BEQ]  &  bus.zero) |
                    (w_sel[c_I_BNE]  & ~bus.zero) |
                    (w_sel[c_I_BGEZ] & ~bus.rs_sign);
  assign w_cnt_zero = (r_cnt == '0);

  // State, MD counter and exception cause registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IF;
      r_cnt   <= '0;
      r_cause <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_cause <= w_cause_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    w_cause_next = r_cause;
    case (r_state)
      c_ST_IF: begin
        if (bus.mem_ready) w_next = c_ST_ID;
      end
      c_ST_ID: begin
        if (!w_any) begin
          w_next       = c_ST_EXC;
          w_cause_next = c_EXC_RI;
        end else begin
          w_next = c_ST_EX;
        end
      end
      c_ST_EX: begin
        if (w_sel[c_I_SYSCALL]) begin
          w_next       = c_ST_EXC;
          w_cause_next = c_EXC_SYS;
        end else if (w_sel[c_I_BREAK]) begin
          w_next       = c_ST_EXC;
          w_cause_next = c_EXC_BP;
        end else if (w_sel[c_I_TEQ]) begin
          if (bus.zero) begin
            w_next       = c_ST_EXC;
            w_cause_next = c_EXC_TR;
          end else begin
            w_next = c_ST_IF;
          end
        end else if (w_branch | w_sel[c_I_J] | w_sel[c_I_JR] | w_sel[c_I_ERET] |
                     w_sel[c_I_MTHI] | w_sel[c_I_MTLO]) begin
          w_next = c_ST_IF;
        end else if (w_mul) begin
          w_next     = c_ST_MD;
          w_cnt_next = c_MUL_LOAD;
        end else if (w_div) begin
          w_next     = c_ST_MD;
          w_cnt_next = c_DIV_LOAD;
        end else if (w_load | w_store) begin
          w_next = c_ST_MEM;
        end else begin
          w_next = c_ST_WB;
        end
      end
      c_ST_MEM: begin
        if (bus.mem_ready) w_next = w_load ? c_ST_WB : c_ST_IF;
      end
      c_ST_WB: begin
        w_next = c_ST_IF;
      end
      c_ST_MD: begin
        if (w_cnt_zero) w_next = c_ST_IF;
        else            w_cnt_next = r_cnt - c_CNT_ONE;
      end
      c_ST_EXC: begin
        w_next = c_ST_IF;
      end
      default: begin
        w_next = c_ST_IF;
      end
    endcase
  end

  // Strobes are forced low while reset is held, even in IF.
  always_comb begin
    w_ir_we     = 1'b0;
    w_pc_we     = 1'b0;
    w_pc_sel    = c_PC_SEQ;
    w_rf_w      = 1'b0;
    w_dm_r      = 1'b0;
    w_dm_w      = 1'b0;
    w_hi_ena    = 1'b0;
    w_lo_ena    = 1'b0;
    w_md_start  = 1'b0;
    w_exception = 1'b0;
    if (!rst) begin
      case (r_state)
        c_ST_IF: begin
          w_ir_we = 1'b1;
          w_pc_we = bus.mem_ready;
        end
        c_ST_EX: begin
          if (w_taken) begin
            w_pc_we  = 1'b1;
            w_pc_sel = c_PC_BR;
          end else if (w_sel[c_I_J] | w_sel[c_I_JAL]) begin
            w_pc_we  = 1'b1;
            w_pc_sel = c_PC_JT;
          end else if (w_sel[c_I_JR] | w_sel[c_I_JALR]) begin
            w_pc_we  = 1'b1;
            w_pc_sel = c_PC_RS;
          end else if (w_sel[c_I_ERET]) begin
            w_pc_we  = 1'b1;
            w_pc_sel = c_PC_EPC;
          end
          w_hi_ena   = w_sel[c_I_MTHI];
          w_lo_ena   = w_sel[c_I_MTLO];
          w_md_start = w_mul | w_div;
        end
        c_ST_MEM: begin
          w_dm_r = w_load;
          w_dm_w = w_store;
        end
        c_ST_WB: begin
          w_rf_w = 1'b1;
        end
        c_ST_MD: begin
          w_hi_ena = w_cnt_zero;
          w_lo_ena = w_cnt_zero;
        end
        c_ST_EXC: begin
          w_exception = 1'b1;
          w_pc_we     = 1'b1;
          w_pc_sel    = c_PC_VEC;
        end
        default: begin
          w_ir_we = 1'b0;
        end
      endcase
    end
  end

  assign bus.ir_we     = w_ir_we;
  assign bus.pc_we     = w_pc_we;
  assign bus.pc_sel    = w_pc_sel;
  assign bus.rf_w      = w_rf_w;
  assign bus.dm_r      = w_dm_r;
  assign bus.dm_w      = w_dm_w;
  assign bus.hi_ena    = w_hi_ena;
  assign bus.lo_ena    = w_lo_ena;
  assign bus.md_start  = w_md_start;
  assign bus.exception = w_exception;
  assign bus.busy      = (r_state != c_ST_IF) && !rst;
  assign bus.cause     = r_cause;
  assign bus.state     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_multicycle_ctrl : scoreboard bench; per-cycle expected control traces   |
// |                      from an instruction-level reference model.            |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_multicycle_ctrl;

  localparam int I_ADDU = 1,  I_JR = 16, I_LW = 22, I_SW = 23, I_BEQ = 24;
  localparam int I_BNE = 25, I_J = 29, I_JAL = 30, I_DIVU = 32, I_ERET = 33;
  localparam int I_JALR = 34, I_LB = 35, I_LBU = 36, I_LHU = 37, I_SB = 38;
  localparam int I_SH = 39, I_LH = 40, I_MTHI = 45, I_MTLO = 46, I_MULT = 47;
  localparam int I_MULTU = 48, I_SYSCALL = 49, I_TEQ = 50, I_BGEZ = 51;
  localparam int I_BREAK = 52, I_DIV = 53;
  localparam int N_MUL = 4, N_DIV = 33;

  typedef struct packed {
    logic [2:0] st;
    logic       ir_we;
    logic       pc_we;
    logic [2:0] pc_sel;
    logic       rf_w;
    logic       dm_r;
    logic       dm_w;
    logic       hi;
    logic       lo;
    logic       md_start;
    logic       exc;
    logic       busy;
    logic [4:0] cause;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  rec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic [4:0] m_cause;

  multicycle_ctrl_if #(.CODE_W(54)) bus ();

  multicycle_ctrl #(
    .CODE_W(54), .MUL_CYCLES(N_MUL), .DIV_CYCLES(N_DIV), .CNT_W(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic rec_t base(input logic [2:0] st);
    rec_t e;
    e       = '0;
    e.st    = st;
    e.busy  = (st != 3'd0);
    e.cause = m_cause;
    return e;
  endfunction

  function automatic rec_t sample();
    rec_t a;
    a.st = bus.state; a.ir_we = bus.ir_we; a.pc_we = bus.pc_we;
    a.pc_sel = bus.pc_sel; a.rf_w = bus.rf_w; a.dm_r = bus.dm_r;
    a.dm_w = bus.dm_w; a.hi = bus.hi_ena; a.lo = bus.lo_ena;
    a.md_start = bus.md_start; a.exc = bus.exception; a.busy = bus.busy;
    a.cause = bus.cause;
    return a;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: one expected record per cycle, pc_sel only meaningful with pc_we.
  always @(negedge clk) begin
    rec_t e;
    rec_t a;
    rec_t m;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = sample();
      m = '1;
      if (!e.pc_we) m.pc_sel = '0;
      total++;
      if (((a ^ e) & m) != '0) begin
        bad++;
        $display("FAIL trace@%0t: got st=%0d vec=%h expected st=%0d vec=%h",
                 $time, a.st, a, e.st, e);
      end
    end
  end

  task automatic cyc(input rec_t e, input logic mr);
    bus.mem_ready = mr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_exc(input logic [4:0] code);
    rec_t e;
    m_cause = code;
    e = base(3'd6);
    e.exc = 1'b1; e.pc_we = 1'b1; e.pc_sel = 3'd5;
    cyc(e, 1'($urandom));
  endtask

  task automatic do_wb();
    rec_t e;
    e = base(3'd4);
    e.rf_w = 1'b1;
    cyc(e, 1'($urandom));
  endtask

  // Reference model: one instruction, idx<0 means an all-zero code vector.
  task automatic run_instr(input int idx, input bit z, input bit rs,
                           input int ifw, input int memw, input bit extra);
    rec_t e;
    logic [63:0] r;
    logic [53:0] one;
    logic [53:0] cv;
    bit ld;
    int n;
    one = 54'd1;
    cv  = '0;
    if (idx >= 0) begin
      r  = {$urandom, $urandom};
      cv = one << idx;
      if (extra) cv = cv | (r[53:0] & ~((one << (idx + 1)) - one));
    end
    bus.code = cv; bus.zero = z; bus.rs_sign = rs;
    for (int i = 0; i < ifw; i++) begin
      e = base(3'd0); e.ir_we = 1'b1; cyc(e, 1'b0);
    end
    e = base(3'd0); e.ir_we = 1'b1; e.pc_we = 1'b1; e.pc_sel = 3'd0;
    cyc(e, 1'b1);
    cyc(base(3'd1), 1'($urandom));
    if (idx < 0) begin
      do_exc(5'b01010);
      return;
    end
    e = base(3'd2);
    case (idx)
      I_BEQ, I_BNE, I_BGEZ: begin
        e.pc_we = (idx == I_BEQ) ? z : (idx == I_BNE) ? !z : !rs;
        e.pc_sel = 3'd1;
        cyc(e, 1'($urandom));
      end
      I_J, I_JAL: begin
        e.pc_we = 1'b1; e.pc_sel = 3'd2; cyc(e, 1'($urandom));
        if (idx == I_JAL) do_wb();
      end
      I_JR, I_JALR: begin
        e.pc_we = 1'b1; e.pc_sel = 3'd3; cyc(e, 1'($urandom));
        if (idx == I_JALR) do_wb();
      end
      I_ERET: begin
        e.pc_we = 1'b1; e.pc_sel = 3'd4; cyc(e, 1'($urandom));
      end
      I_SYSCALL: begin cyc(e, 1'($urandom)); do_exc(5'b01000); end
      I_BREAK:   begin cyc(e, 1'($urandom)); do_exc(5'b01001); end
      I_TEQ: begin
        cyc(e, 1'($urandom));
        if (z) do_exc(5'b01101);
      end
      I_MULT, I_MULTU, I_DIV, I_DIVU: begin
        e.md_start = 1'b1; cyc(e, 1'($urandom));
        n = (idx == I_MULT || idx == I_MULTU) ? N_MUL : N_DIV;
        for (int k = 0; k < n; k++) begin
          e = base(3'd5);
          e.hi = (k == n - 1); e.lo = (k == n - 1);
          cyc(e, 1'($urandom));
        end
      end
      I_LW, I_LH, I_LHU, I_LB, I_LBU, I_SW, I_SH, I_SB: begin
        ld = (idx == I_LW || idx == I_LH || idx == I_LHU || idx == I_LB || idx == I_LBU);
        cyc(e, 1'($urandom));
        e = base(3'd3); e.dm_r = ld; e.dm_w = !ld;
        for (int k = 0; k < memw; k++) cyc(e, 1'b0);
        cyc(e, 1'b1);
        if (ld) do_wb();
      end
      I_MTHI: begin e.hi = 1'b1; cyc(e, 1'($urandom)); end
      I_MTLO: begin e.lo = 1'b1; cyc(e, 1'($urandom)); end
      default: begin cyc(e, 1'($urandom)); do_wb(); end
    endcase
  endtask

  // DIV aborted by reset in its tenth MD cycle.
  task automatic md_reset_abort();
    rec_t e;
    bus.code = 54'd1 << I_DIV; bus.zero = 1'b0; bus.rs_sign = 1'b0;
    e = base(3'd0); e.ir_we = 1'b1; e.pc_we = 1'b1; cyc(e, 1'b1);
    cyc(base(3'd1), 1'b0);
    e = base(3'd2); e.md_start = 1'b1; cyc(e, 1'b0);
    for (int k = 0; k < 9; k++) cyc(base(3'd5), 1'b0);
    #2;
    check("md10_state", int'(bus.state), 5);
    rst = 1'b1;
    #1;
    check("abort_state", int'(bus.state), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_hi_ena", int'(bus.hi_ena), 0);
    check("abort_cause", int'(bus.cause), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_cause = '0;
    check("post_rst_state", int'(bus.state), 0);
  endtask

  initial begin
    int idx;
    rst = 1'b1;
    m_cause = '0;
    bus.code = '0; bus.zero = 1'b0; bus.rs_sign = 1'b0; bus.mem_ready = 1'b1;
    #12;
    check("rst_state", int'(bus.state), 0);
    check("rst_ir_we", int'(bus.ir_we), 0);
    check("rst_pc_we", int'(bus.pc_we), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_cause", int'(bus.cause), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_instr(I_ADDU, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(I_LW, 1'b0, 1'b0, 1, 3, 1'b0);
    run_instr(I_SW, 1'b0, 1'b0, 0, 2, 1'b0);
    run_instr(I_DIV, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(I_MULT, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(I_TEQ, 1'b1, 1'b0, 0, 0, 1'b0);
    run_instr(I_TEQ, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(-1, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(I_BGEZ, 1'b0, 1'b1, 0, 0, 1'b0);
    run_instr(I_BGEZ, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(I_BEQ, 1'b1, 1'b0, 2, 0, 1'b0);
    run_instr(I_JALR, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(I_SYSCALL, 1'b0, 1'b0, 0, 0, 1'b1);
    run_instr(I_MTHI, 1'b0, 1'b0, 0, 0, 1'b1);
    md_reset_abort();

    for (int n = 0; n < 250; n++) begin
      idx = int'($urandom_range(0, 54));
      if (idx == 54) idx = -1;
      run_instr(idx, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    #1;
    check("queue_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter CODE_W, default 54: width of the one-hot decoded instruction vector.
REQ-002 SHALL have parameter MUL_CYCLES, default 4: cycles spent in state MD for MULT/MULTU, legal range 1..2^CNT_W.
REQ-003 SHALL have parameter DIV_CYCLES, default 33: cycles spent in state MD for DIV/DIVU, legal range 1..2^CNT_W.
REQ-004 SHALL have parameter CNT_W, default 6: width of the MD cycle counter.
REQ-005 SHALL have ports: clk  in  1  system clock, all state changes on rising edge.
REQ-006 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports: code  in  CODE_W  one-hot decoded instruction, bit indices as the 54-instruction decode table (ADD=0 ... DIV=53), valid from ID onward.
REQ-008 SHALL have ports: zero  in  1  ALU result zero; rs_sign  in  1  Rs[31]; mem_ready  in  1  IMEM/DMEM access complete.
REQ-009 SHALL have ports: ir_we  out  1  instruction register load; pc_we  out  1  PC write; pc_sel  out  3  PC source (0 PC+4, 1 branch target, 2 J target, 3 Rs, 4 EPC, 5 exception vector).
REQ-010 SHALL have ports: rf_w, dm_r, dm_w, hi_ena, lo_ena  out  1 each  register file write / DMEM read / DMEM write / HI write / LO write.
REQ-011 SHALL have ports: md_start  out  1  one-cycle multiply/divide start pulse; busy  out  1  high in any state other than IF.
REQ-012 SHALL have ports: exception  out  1  CP0 exception strobe; cause  out  5  registered exception code; state  out  3  current state, for debug.

Function
REQ-013 SHALL implement states IF=0, ID=1, EX=2, MEM=3, WB=4, MD=5, EXC=6; all outputs except cause, state and busy combinational from state, code, zero, rs_sign and mem_ready.
REQ-014 IF: ir_we=1; when mem_ready=1 assert pc_we with pc_sel=0 and go to ID, else hold IF with pc_we=0.
REQ-015 ID: code==0 (reserved instruction) -> EXC with cause 5'b01010; otherwise -> EX.
REQ-016 EX, taken BEQ(zero=1), BNE(zero=0) or BGEZ(rs_sign=0): pc_we=1, pc_sel=1, -> IF; untaken branch -> IF with pc_we=0.
REQ-017 EX, J: pc_we=1, pc_sel=2, -> IF. JAL: pc_sel=2 -> WB. JR: pc_sel=3 -> IF. JALR: pc_sel=3 -> WB. ERET: pc_sel=4 -> IF.
REQ-018 EX, SYSCALL -> EXC with cause 5'b01000; BREAK -> EXC with 5'b01001; TEQ with zero=1 -> EXC with 5'b01101; TEQ with zero=0 -> IF.
REQ-019 EX, MULT/MULTU/DIV/DIVU: md_start=1 for exactly this cycle; counter loaded with MUL_CYCLES-1 or DIV_CYCLES-1; -> MD.
REQ-020 EX, LW/LH/LHU/LB/LBU/SW/SH/SB -> MEM; MTHI/MTLO: hi_ena/lo_ena=1 respectively, -> IF; all other instructions -> WB.
REQ-021 MEM: dm_r=1 for loads, dm_w=1 for stores, held until mem_ready=1; then loads -> WB, stores -> IF.
REQ-022 WB: rf_w=1 for exactly one cycle, -> IF.
REQ-023 MD: counter decrements by 1 per cycle; in the cycle it reads 0, hi_ena=lo_ena=1, -> IF; MUL_CYCLES=1 yields exactly one MD cycle.
REQ-024 EXC: exception=1, pc_we=1, pc_sel=5, -> IF; cause is updated on entry to EXC and holds until the next exception.
REQ-025 rf_w, dm_w, hi_ena and lo_ena SHALL never be asserted outside WB, MEM, MD and EX-for-MTHI/MTLO respectively.
REQ-026 A code vector with more than one bit set SHALL be treated using the lowest-index set bit.

Reset
REQ-027 rst=1 SHALL force state=IF, counter=0 and cause=0 immediately, without waiting for clk; this includes abort of MD or MEM mid-operation.
REQ-028 While rst=1, pc_we=0, rf_w=0, dm_w=0, dm_r=0, hi_ena=0, lo_ena=0, md_start=0, exception=0, ir_we=0 and busy=0.

Verification
REQ-029 ADDU, mem_ready=1 -> states IF,ID,EX,WB; rf_w=1 only in WB; 4 cycles total.
REQ-030 LW with mem_ready held low 3 cycles in MEM -> dm_r=1 for 4 cycles, then WB with rf_w=1, pc_we=0 throughout MEM.
REQ-031 DIV with default parameters -> md_start single pulse in EX, 33 MD cycles, hi_ena=lo_ena=1 only in the last MD cycle.
REQ-032 TEQ with zero=1 -> EXC, exception=1, pc_sel=5, cause=5'b01101; TEQ with zero=0 -> IF, cause unchanged.
REQ-033 rst asserted in 10th MD cycle -> state=0, busy=0, hi_ena=0 asynchronously; after release, the next cycle is IF.
REQ-034 code=0 -> ID->EXC, cause=5'b01010; BGEZ with rs_sign=1 -> pc_we=0 in EX.
